// File: rtl/mac_uint8_int32.sv
// Single-lane unsigned multiply-accumulate with a registered accumulator and valid flag.
// Build option: define MAC_SATURATE_EN to clamp the accumulator at all-ones instead of wrapping.
module mac_uint8_int32 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] weight_in,
  input  logic              enable,
  input  logic              clear_acc,
  output logic [ACC_W-1:0]  acc_out,
  output logic              valid
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  acc_next;
  logic              valid_reg;
  logic              valid_next;
  logic [ACC_W-1:0]  sum_value;

  // Operands are zero-extended first so the product is formed at full width.
  assign product = {{DATA_W{1'b0}}, data_in} * {{DATA_W{1'b0}}, weight_in};

`ifdef MAC_SATURATE_EN
  logic [ACC_W:0] sum_wide;

  // The extra carry bit flags an overflow; clamp to all-ones when it is set.
  assign sum_wide  = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
  assign sum_value = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign sum_value = acc_reg + {{(ACC_W - PROD_W){1'b0}}, product};
`endif

  always_comb begin
    acc_next   = acc_reg;
    valid_next = 1'b0;
    if (clear_acc) begin
      acc_next = '0;
    end else if (enable) begin
      acc_next   = sum_value;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      valid_reg <= valid_next;
    end
  end

  assign acc_out = acc_reg;
  assign valid   = valid_reg;

endmodule

// File: tb/tb_mac_uint8_int32.sv
// Directed bench for mac_uint8_int32: a per-cycle scoreboard of expected acc/valid plus
// fixed checkpoint values for the reference sums.
module tb_mac_uint8_int32;

  logic        clock;
  logic        reset;
  logic [7:0]  data_in;
  logic [7:0]  weight_in;
  logic        enable;
  logic        clear_acc;
  logic [31:0] acc_out;
  logic        valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] acc;
    logic        vld;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_acc = '0;
  logic        m_valid = 1'b0;

  mac_uint8_int32 #(.DATA_W(8), .ACC_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .weight_in (weight_in),
    .enable    (enable),
    .clear_acc (clear_acc),
    .acc_out   (acc_out),
    .valid     (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare once the edge has passed.
  task automatic cycle(input logic rst, input logic clr, input logic en,
                       input logic [7:0] d, input logic [7:0] w);
    exp_t        e;
    longint      s;
    reset     = rst;
    clear_acc = clr;
    enable    = en;
    data_in   = d;
    weight_in = w;
    if (rst || clr) begin
      m_acc   = '0;
      m_valid = 1'b0;
    end else if (en) begin
      s = longint'(m_acc) + longint'(d) * longint'(w);
`ifdef MAC_SATURATE_EN
      m_acc = (s > 64'sd4294967295) ? 32'hFFFF_FFFF : s[31:0];
`else
      m_acc = s[31:0];
`endif
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    e.acc = m_acc;
    e.vld = m_valid;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check32("sb_acc", acc_out, e.acc);
    check1("sb_valid", valid, e.vld);
  endtask

  // Dot product with deterministic pseudo-activations; the sum is tallied separately.
  task automatic dot(input string name, input int n, input int seed);
    longint total = 0;
    logic [7:0] d, w;
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < n; i++) begin
      d = 8'((i * 37 + seed * 11 + 5) % 256);
      w = 8'((i * 91 + seed * 29 + 3) % 256);
      total += longint'(d) * longint'(w);
      cycle(1'b0, 1'b0, 1'b1, d, w);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check32({name, "_sum"}, acc_out, total[31:0]);
    check1({name, "_valid_drop"}, valid, 1'b0);
    $display("dot %s n=%0d acc=%0d", name, n, acc_out);
  endtask

  initial begin
    reset = 1'b1; clear_acc = 1'b0; enable = 1'b0; data_in = '0; weight_in = '0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 8'd9, 8'd9);
    check32("reset_acc", acc_out, 32'd0);
    check1("reset_valid", valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'd9, 8'd9);
    cycle(1'b0, 1'b0, 1'b0, 8'd9, 8'd9);
    check32("idle_after_reset", acc_out, 32'd0);
    $display("reset acc=%0d valid=%0b", acc_out, valid);

    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'd255, 8'd255);
      check1("max_valid_high", valid, 1'b1);
    end
    check32("max_3x", acc_out, 32'd195075);
    cycle(1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    check1("max_valid_drop", valid, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'd7, 8'd7);
    check32("max_hold", acc_out, 32'd195075);
    $display("max3 acc=%0d", acc_out);

    dot("conv1_f0_5_5", 27, 1);
    dot("conv1_f0_0_0", 27, 2);
    dot("conv2_f0_4_4", 144, 3);
    dot("fc2_n0", 64, 4);

    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'd10, 8'd10);
    check32("prio_pre", acc_out, 32'd100);
    cycle(1'b0, 1'b1, 1'b1, 8'd7, 8'd7);
    check32("prio_clear_acc", acc_out, 32'd0);
    check1("prio_clear_valid", valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'd7, 8'd7);
    check32("prio_after", acc_out, 32'd49);
    $display("clear priority acc=%0d", acc_out);

    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 66052; i++) cycle(1'b0, 1'b0, 1'b1, 8'd255, 8'd255);
`ifdef MAC_SATURATE_EN
    check32("sat_limit", acc_out, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'd255, 8'd255);
    check32("sat_hold", acc_out, 32'hFFFF_FFFF);
`else
    check32("wrap_value", acc_out, 32'd64004);
    cycle(1'b0, 1'b0, 1'b1, 8'd255, 8'd255);
    check32("wrap_next", acc_out, 32'd129029);
`endif
    $display("overflow run acc=%0d", acc_out);

    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'd3, 8'd4);
    check32("mid_partial", acc_out, 32'd60);
    cycle(1'b1, 1'b0, 1'b1, 8'd3, 8'd4);
    check32("mid_reset_acc", acc_out, 32'd0);
    check1("mid_reset_valid", valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'd2, 8'd2);
    check32("mid_after", acc_out, 32'd4);
    check1("mid_after_valid", valid, 1'b1);
    $display("reset mid-stream acc=%0d", acc_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
